// File: rtl/fa_call_pkg.sv
// Shared types and default sizing for the cabin call-handling blocks.
package fa_call_pkg;

  localparam int unsigned DEF_N_SEATS    = 8;
  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_ESC_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALERT   = 2'd1,
    ST_ENROUTE = 2'd2
  } call_state_e;

endpackage

// File: rtl/fa_rr_pick.sv
// Combinational round-robin picker: first set req bit after `last`, wrapping to 0.
module fa_rr_pick #(
  parameter int unsigned N_SEATS = 8,
  parameter int unsigned SEAT_W  = $clog2(N_SEATS)
) (
  input  logic [N_SEATS-1:0] req,
  input  logic [SEAT_W-1:0]  last,
  output logic [SEAT_W-1:0]  grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 1; k <= N_SEATS; k++) begin
      idx = (32'(last) + k) % N_SEATS;
      if (!grant_valid && req[SEAT_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = SEAT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/attendant_call_panel.sv
// Galley responder for seat call lights: latches calls, alerts one seat at a time round-robin.
// Optional ALERT timeout escalation is built when CALL_ESCALATE_EN is defined.
module attendant_call_panel
  import fa_call_pkg::*;
#(
  parameter int unsigned N_SEATS    = DEF_N_SEATS,
  parameter int unsigned SEAT_W     = $clog2(N_SEATS),
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned ESC_CYCLES = DEF_ESC_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SEATS-1:0] seat_call,
  input  logic               attend,
  input  logic               clear,
  output logic [SEAT_W-1:0]  alert_seat,
  output logic               alert_valid,
  output logic               busy,
  output logic               chime,
  output logic [N_SEATS-1:0] pending,
  output logic [CNT_W-1:0]   serviced_cnt,
  output logic               escalate
);

  call_state_e        state_q, state_d;
  logic [N_SEATS-1:0] seat_call_q, rise, dismiss, pending_d;
  logic [SEAT_W-1:0]  last_seat, last_d, seat_d, pick_idx;
  logic [CNT_W-1:0]   cnt_d;
  logic               pick_valid, alert_valid_d, busy_d, chime_d, escalate_d;

`ifdef CALL_ESCALATE_EN
  localparam int unsigned ESC_CNT_W = $clog2(ESC_CYCLES + 1);
  logic [ESC_CNT_W-1:0] esc_cnt, esc_cnt_d;
`else
  logic unused_esc;
  assign unused_esc = ^ESC_CYCLES;
`endif

  assign rise = seat_call & ~seat_call_q;

  fa_rr_pick #(
    .N_SEATS (N_SEATS),
    .SEAT_W  (SEAT_W)
  ) u_pick (
    .req         (pending),
    .last        (last_seat),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Next-state, next-output and pending-update logic.
  always_comb begin
    state_d    = state_q;
    seat_d     = alert_seat;
    last_d     = last_seat;
    cnt_d      = serviced_cnt;
    chime_d    = 1'b0;
    escalate_d = 1'b0;
    dismiss    = '0;
`ifdef CALL_ESCALATE_EN
    esc_cnt_d  = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ALERT;
          seat_d  = pick_idx;
          chime_d = 1'b1;
        end
      end
      ST_ALERT: begin
        if (!seat_call[alert_seat]) begin
          state_d = ST_IDLE;
          last_d  = alert_seat;
        end else if (clear) begin
          state_d             = ST_IDLE;
          dismiss[alert_seat] = 1'b1;
          last_d              = alert_seat;
        end else if (attend) begin
          state_d = ST_ENROUTE;
        end
      end
      ST_ENROUTE: begin
        if (!seat_call[alert_seat]) begin
          state_d = ST_IDLE;
          last_d  = alert_seat;
          cnt_d   = (serviced_cnt == '1) ? serviced_cnt : serviced_cnt + CNT_W'(1);
        end else if (clear) begin
          state_d             = ST_IDLE;
          dismiss[alert_seat] = 1'b1;
          last_d              = alert_seat;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CALL_ESCALATE_EN
    // Timer runs only while ALERT is held; each expiry re-chimes and restarts it.
    if (state_q == ST_ALERT && state_d == ST_ALERT) begin
      escalate_d = escalate;
      if (esc_cnt == ESC_CNT_W'(ESC_CYCLES - 1)) begin
        escalate_d = 1'b1;
        chime_d    = 1'b1;
      end else begin
        esc_cnt_d = esc_cnt + ESC_CNT_W'(1);
      end
    end
`endif

    pending_d     = seat_call & ~dismiss & (rise | pending);
    alert_valid_d = (state_d == ST_ALERT);
    busy_d        = (state_d == ST_ENROUTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      seat_call_q  <= '0;
      last_seat    <= SEAT_W'(N_SEATS - 1);
      alert_seat   <= '0;
      alert_valid  <= 1'b0;
      busy         <= 1'b0;
      chime        <= 1'b0;
      pending      <= '0;
      serviced_cnt <= '0;
      escalate     <= 1'b0;
`ifdef CALL_ESCALATE_EN
      esc_cnt      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seat_call_q  <= seat_call;
      last_seat    <= last_d;
      alert_seat   <= seat_d;
      alert_valid  <= alert_valid_d;
      busy         <= busy_d;
      chime        <= chime_d;
      pending      <= pending_d;
      serviced_cnt <= cnt_d;
      escalate     <= escalate_d;
`ifdef CALL_ESCALATE_EN
      esc_cnt      <= esc_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_attendant_call_panel.sv
// Directed vector bench for attendant_call_panel with 4 seats and a 3-bit counter.
module tb_attendant_call_panel;

  localparam int unsigned NS  = 4;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned ESC = 5;
`ifdef CALL_ESCALATE_EN
  localparam logic EXP_ESC = 1'b1;
`else
  localparam logic EXP_ESC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] seat_call;
  logic          attend, clear;
  logic [SW-1:0] alert_seat;
  logic          alert_valid, busy, chime, escalate;
  logic [NS-1:0] pending;
  logic [CW-1:0] serviced_cnt;

  int n_vec = 0;
  int n_bad = 0;

  attendant_call_panel #(
    .N_SEATS(NS), .SEAT_W(SW), .CNT_W(CW), .ESC_CYCLES(ESC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seat_call(seat_call), .attend(attend), .clear(clear),
    .alert_seat(alert_seat), .alert_valid(alert_valid), .busy(busy), .chime(chime),
    .pending(pending), .serviced_cnt(serviced_cnt), .escalate(escalate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NS-1:0] sc;
    logic          at, cl;
    logic [SW-1:0] seat;
    logic          av, bz, ch;
    logic [NS-1:0] pd;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [NS-1:0] sc, input logic at,
                              input logic cl, input logic [SW-1:0] seat, input logic av,
                              input logic bz, input logic ch, input logic [NS-1:0] pd,
                              input logic [CW-1:0] cnt);
    vec_t v;
    v.rst = r; v.sc = sc; v.at = at; v.cl = cl; v.seat = seat;
    v.av = av; v.bz = bz; v.ch = ch; v.pd = pd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply inputs just after a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [NS-1:0] sc, input logic at, input logic cl);
    seat_call = sc; attend = at; clear = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            rst  sc       at cl  seat av bz ch pd       cnt
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 2, 1, 0, 1, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 2, 1, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, 2, 0, 1, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 2, 0, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 0, 0, 0, 0, 0, 4'b1011, 0));
    vecs.push_back(mk(0, 4'b1011, 0, 0, 0, 1, 0, 1, 4'b1011, 0));
    vecs.push_back(mk(0, 4'b1011, 1, 0, 0, 0, 1, 0, 4'b1011, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 0, 0, 0, 0, 4'b1010, 1));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 1, 1, 0, 1, 4'b1010, 1));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 1, 0, 1, 0, 4'b1010, 1));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 0, 0, 0, 4'b1000, 2));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 3, 1, 0, 1, 4'b1000, 2));
    vecs.push_back(mk(0, 4'b1000, 1, 0, 3, 0, 1, 0, 4'b1000, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3, 0, 0, 0, 4'b0000, 3));
    vecs.push_back(mk(0, 4'b1001, 0, 0, 3, 0, 0, 0, 4'b1001, 3));
    vecs.push_back(mk(0, 4'b1001, 0, 0, 0, 1, 0, 1, 4'b1001, 3));
    vecs.push_back(mk(0, 4'b1001, 1, 0, 0, 0, 1, 0, 4'b1001, 3));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 0, 0, 0, 0, 4'b1000, 4));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 3, 1, 0, 1, 4'b1010, 4));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 3, 0, 1, 0, 4'b1010, 4));
    vecs.push_back(mk(0, 4'b1010, 0, 1, 3, 0, 0, 0, 4'b0010, 4));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 1, 1, 0, 1, 4'b0010, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 0, 0, 0, 4'b0000, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 0, 0, 0, 4'b0000, 4));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 1, 0, 0, 0, 4'b1000, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 3, 1, 0, 1, 4'b1000, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 1, 3, 0, 0, 0, 4'b0000, 4));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 3, 0, 0, 0, 4'b0000, 4));

    rst_n = 1'b0; seat_call = '0; attend = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({alert_seat, alert_valid, busy, chime, pending, serviced_cnt, escalate}), 32'd0);

    foreach (vecs[i]) begin
      logic [13:0] got, exp;
      rst_n = ~vecs[i].rst;
      step(vecs[i].sc, vecs[i].at, vecs[i].cl);
      got = {alert_seat, alert_valid, busy, chime, pending, serviced_cnt, escalate};
      exp = {vecs[i].seat, vecs[i].av, vecs[i].bz, vecs[i].ch, vecs[i].pd, vecs[i].cnt, 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got seat=%0d av=%b bz=%b ch=%b pd=%b cnt=%0d esc=%b expected seat=%0d av=%b bz=%b ch=%b pd=%b cnt=%0d esc=0",
                 i, alert_seat, alert_valid, busy, chime, pending, serviced_cnt, escalate,
                 vecs[i].seat, vecs[i].av, vecs[i].bz, vecs[i].ch, vecs[i].pd, vecs[i].cnt);
      end
    end

    // Counter saturation: 4 -> 5, 6, 7, 7.
    step(4'b0000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 0, 0);
      step(4'b0001, 0, 0);
      chk("sat_alert_valid", 32'(alert_valid), 32'd1);
      step(4'b0001, 1, 0);
      step(4'b0000, 0, 0);
      chk("sat_count", 32'(serviced_cnt), (k + 5 > 7) ? 32'd7 : 32'(k + 5));
    end

    // Asynchronous reset mid-service; a light still high is re-detected afterwards.
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 1, 0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           32'({alert_seat, alert_valid, busy, chime, pending, serviced_cnt, escalate}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 0, 0);
    chk("post_reset_pending", 32'({alert_valid, pending}), 32'({1'b0, 4'b0100}));
    step(4'b0100, 0, 0);
    chk("post_reset_alert", 32'({alert_seat, alert_valid, chime}), 32'({2'd2, 1'b1, 1'b1}));

    // ALERT held without attend: escalation only when the option is built.
    for (int k = 1; k <= 4; k++) begin
      step(4'b0100, 0, 0);
      chk("esc_wait", 32'({alert_valid, chime, escalate}), 32'({1'b1, 1'b0, 1'b0}));
    end
    step(4'b0100, 0, 0);
    chk("esc_fire", 32'({alert_valid, chime, escalate}), 32'({1'b1, EXP_ESC, EXP_ESC}));
    step(4'b0100, 0, 0);
    chk("esc_hold", 32'({chime, escalate}), 32'({1'b0, EXP_ESC}));
    step(4'b0100, 1, 0);
    chk("esc_attend", 32'({busy, escalate}), 32'({1'b1, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
